// File: rtl/sprite_renderer_if.sv
// Frame request, sprite table and pixel write bus between the game datapath and sprite_renderer.
interface sprite_renderer_if #(
  parameter int unsigned NUM_OBJ = 2,
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 7,
  parameter int unsigned CW      = 3
);
  logic                  frame_tick;
  logic [NUM_OBJ*XW-1:0] obj_x;
  logic [NUM_OBJ*YW-1:0] obj_y;
  logic [NUM_OBJ*CW-1:0] obj_colour;
  logic [NUM_OBJ-1:0]    obj_en;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [CW-1:0]         colour;
  logic                  plot;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  modport master (
    output frame_tick, obj_x, obj_y, obj_colour, obj_en,
    input  x, y, colour, plot, busy, done, overrun
  );

  modport slave (
    input  frame_tick, obj_x, obj_y, obj_colour, obj_en,
    output x, y, colour, plot, busy, done, overrun
  );
endinterface

// File: rtl/sprite_renderer.sv
// Per-frame erase/redraw of NUM_OBJ rectangular sprites, one registered pixel write per cycle.
// Optional SPRITE_RENDERER_DIRTY_SKIP_EN skips objects whose position/colour/enable are unchanged.
module sprite_renderer #(
  parameter int unsigned NUM_OBJ   = 2,
  parameter int unsigned SPR_W     = 4,
  parameter int unsigned SPR_H     = 4,
  parameter int unsigned XW        = 8,
  parameter int unsigned YW        = 7,
  parameter int unsigned CW        = 3,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter int unsigned BG_COLOUR = 0
) (
  input logic               clock,
  input logic               reset,
  sprite_renderer_if.slave  bus
);

  localparam int unsigned IW   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int unsigned ColW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned RowW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [XW:0]      ScrW    = (XW+1)'(SCREEN_W);
  localparam logic [YW:0]      ScrH    = (YW+1)'(SCREEN_H);
  localparam logic [CW-1:0]    Bg      = CW'(BG_COLOUR);
  localparam logic [IW-1:0]    LastIdx = IW'(NUM_OBJ - 1);
  localparam logic [ColW-1:0]  LastCol = ColW'(SPR_W - 1);
  localparam logic [RowW-1:0]  LastRow = RowW'(SPR_H - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StErase, StDraw, StNext, StFin} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;

  logic [XW-1:0]      cur_x_q   [NUM_OBJ];
  logic [XW-1:0]      cur_x_d   [NUM_OBJ];
  logic [YW-1:0]      cur_y_q   [NUM_OBJ];
  logic [YW-1:0]      cur_y_d   [NUM_OBJ];
  logic [CW-1:0]      cur_col_q [NUM_OBJ];
  logic [CW-1:0]      cur_col_d [NUM_OBJ];
  logic [NUM_OBJ-1:0] cur_en_q, cur_en_d;

  logic [XW-1:0]      prev_x_q [NUM_OBJ];
  logic [YW-1:0]      prev_y_q [NUM_OBJ];
  logic [NUM_OBJ-1:0] prev_valid_q;
`ifdef SPRITE_RENDERER_DIRTY_SKIP_EN
  logic [CW-1:0]      prev_col_q [NUM_OBJ];
`endif

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          busy_q, done_q, overrun_q;

  logic [IW-1:0] ent_idx;
  logic          ent_same;
  state_e        ent_state;
  logic          last_px;
  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic          pix_on;

  // cur_* take the bus inputs only at the end of LATCH; the _d view feeds same-edge decisions.
  always_comb begin
    for (int k = 0; k < NUM_OBJ; k++) begin
      cur_x_d[k]   = cur_x_q[k];
      cur_y_d[k]   = cur_y_q[k];
      cur_col_d[k] = cur_col_q[k];
      cur_en_d[k]  = cur_en_q[k];
      if (state_q == StLatch) begin
        cur_x_d[k]   = bus.obj_x[k*XW +: XW];
        cur_y_d[k]   = bus.obj_y[k*YW +: YW];
        cur_col_d[k] = bus.obj_colour[k*CW +: CW];
        cur_en_d[k]  = bus.obj_en[k];
      end
    end
  end

  // First phase with work for the object about to be scheduled, so empty phases cost no cycles.
  always_comb begin
    ent_idx = (state_q == StLatch) ? '0 : idx_q + 1'b1;
`ifdef SPRITE_RENDERER_DIRTY_SKIP_EN
    ent_same = (cur_en_d[ent_idx] == prev_valid_q[ent_idx]) &&
               (cur_x_d[ent_idx] == prev_x_q[ent_idx]) &&
               (cur_y_d[ent_idx] == prev_y_q[ent_idx]) &&
               (cur_col_d[ent_idx] == prev_col_q[ent_idx]);
`else
    ent_same = 1'b0;
`endif
    if (ent_same)                    ent_state = StNext;
    else if (prev_valid_q[ent_idx])  ent_state = StErase;
    else if (cur_en_d[ent_idx])      ent_state = StDraw;
    else                             ent_state = StNext;
  end

  assign last_px = (row_q == LastRow) && (col_q == LastCol);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick) state_d = StLatch;
      end
      StLatch: begin
        idx_d   = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = ent_state;
      end
      StErase, StDraw: begin
        if (last_px) begin
          row_d = '0;
          col_d = '0;
          state_d = (state_q == StErase && cur_en_q[idx_q]) ? StDraw : StNext;
        end else if (col_q == LastCol) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StNext: begin
        if (idx_q == LastIdx) begin
          state_d = StFin;
        end else begin
          idx_d   = ent_idx;
          state_d = ent_state;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pixel for the next cycle, registered so outputs line up with the state they belong to.
  always_comb begin
    pix_on   = (state_d == StErase) || (state_d == StDraw);
    base_x   = (state_d == StErase) ? prev_x_q[idx_d] : cur_x_d[idx_d];
    base_y   = (state_d == StErase) ? prev_y_q[idx_d] : cur_y_d[idx_d];
    x_sum    = {1'b0, base_x} + (XW+1)'(col_d);
    y_sum    = {1'b0, base_y} + (YW+1)'(row_d);
    x_d      = x_sum[XW-1:0];
    y_d      = y_sum[YW-1:0];
    colour_d = (state_d == StErase) ? Bg : cur_col_d[idx_d];
    plot_d   = pix_on && (x_sum < ScrW) && (y_sum < ScrH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cur_en_q     <= '0;
      prev_valid_q <= '0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        cur_x_q[k]   <= '0;
        cur_y_q[k]   <= '0;
        cur_col_q[k] <= '0;
        prev_x_q[k]  <= '0;
        prev_y_q[k]  <= '0;
`ifdef SPRITE_RENDERER_DIRTY_SKIP_EN
        prev_col_q[k] <= '0;
`endif
      end
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cur_en_q <= cur_en_d;
      for (int k = 0; k < NUM_OBJ; k++) begin
        cur_x_q[k]   <= cur_x_d[k];
        cur_y_q[k]   <= cur_y_d[k];
        cur_col_q[k] <= cur_col_d[k];
      end
      if (state_q == StNext) begin
        prev_x_q[idx_q]     <= cur_x_q[idx_q];
        prev_y_q[idx_q]     <= cur_y_q[idx_q];
        prev_valid_q[idx_q] <= cur_en_q[idx_q];
`ifdef SPRITE_RENDERER_DIRTY_SKIP_EN
        prev_col_q[idx_q]   <= cur_col_q[idx_q];
`endif
      end
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StFin);
      overrun_q <= bus.frame_tick && (state_q != StIdle);
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.plot    = plot_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: expected pixels are queued by the stimulus and
// popped by a negedge monitor; frame timing, overrun and reset abort are checked directly.
module tb_sprite_renderer;

`ifdef SPRITE_RENDERER_DIRTY_SKIP_EN
  localparam bit Dirty = 1'b1;
`else
  localparam bit Dirty = 1'b0;
`endif
  localparam int Bound = 300;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  pix_t exp_q[$];
  pix_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   first_plot;
  int   ovr_cnt;

  sprite_renderer_if #(.NUM_OBJ(2), .XW(8), .YW(7), .CW(3)) bus ();

  sprite_renderer #(
    .NUM_OBJ(2), .SPR_W(4), .SPR_H(4), .XW(8), .YW(7), .CW(3),
    .SCREEN_W(160), .SCREEN_H(120), .BG_COLOUR(0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: every plot must match the oldest queued expectation.
  always @(negedge clock) begin
    if (bus.plot === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, want no plot",
                 bus.x, bus.y, bus.colour);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.x, bus.y, bus.colour} !== {mon_e.x, mon_e.y, mon_e.c}) begin
          miscompares++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d",
                   bus.x, bus.y, bus.colour, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  // Queue the on-screen pixels of one 4x4 sprite in row-major order.
  task automatic push_sprite(input int x0, input int y0, input int c);
    pix_t p;
    for (int r = 0; r < 4; r++) begin
      for (int cc = 0; cc < 4; cc++) begin
        if (x0 + cc < 160 && y0 + r < 120) begin
          p.x = 8'(x0 + cc);
          p.y = 7'(y0 + r);
          p.c = 3'(c);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic set_obj(input int k, input int ox, input int oy, input int c, input bit en);
    bus.obj_x[k*8 +: 8]      = 8'(ox);
    bus.obj_y[k*7 +: 7]      = 7'(oy);
    bus.obj_colour[k*3 +: 3] = 3'(c);
    bus.obj_en[k]            = en;
  endtask

  // Pulse frame_tick (cycle 0), optionally a second tick at cycle `extra`, and time `done`.
  task automatic run_frame(input string name, input int exp_done, input int extra);
    int got;
    got        = -1;
    first_plot = -1;
    ovr_cnt    = 0;
    @(posedge clock); #1;
    bus.frame_tick = 1'b1;
    for (int n = 1; n <= Bound; n++) begin
      @(posedge clock); #1;
      if (n == 1 || n == extra + 1) bus.frame_tick = 1'b0;
      if (n == extra) bus.frame_tick = 1'b1;
      if (bus.plot === 1'b1 && first_plot < 0) first_plot = n;
      if (bus.overrun === 1'b1) ovr_cnt++;
      if (bus.done === 1'b1) begin
        got = n;
        break;
      end
    end
    check({name, "_done_cycle"}, got, exp_done);
    check({name, "_pending_pixels"}, exp_q.size(), 0);
    @(posedge clock); #1;
    check({name, "_busy_after"}, int'(bus.busy), 0);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.obj_x      = '0;
    bus.obj_y      = '0;
    bus.obj_colour = '0;
    bus.obj_en     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_plot", int'(bus.plot), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_overrun", int'(bus.overrun), 0);
    check("reset_xy", int'({bus.x, bus.y, bus.colour}), 0);
    reset = 1'b0;

    // Frame 1: nothing drawn yet, draw only.
    set_obj(0, 20, 60, 4, 1'b1);
    set_obj(1, 150, 100, 1, 1'b1);
    push_sprite(20, 60, 4);
    push_sprite(150, 100, 1);
    run_frame("f1", 36, 0);
    check("f1_first_plot", first_plot, 2);
    check("f1_no_overrun", ovr_cnt, 0);

    // Frame 2: obj0 moves up 2 rows; obj1 unchanged.
    set_obj(0, 20, 58, 4, 1'b1);
    push_sprite(20, 60, 0);
    push_sprite(20, 58, 4);
    if (!Dirty) begin
      push_sprite(150, 100, 0);
      push_sprite(150, 100, 1);
    end
    run_frame("f2", Dirty ? 36 : 68, 0);

    // Frame 3: obj1 at x=158, two columns clipped.
    set_obj(1, 158, 100, 1, 1'b1);
    if (!Dirty) begin
      push_sprite(20, 58, 0);
      push_sprite(20, 58, 4);
    end
    push_sprite(150, 100, 0);
    push_sprite(158, 100, 1);
    run_frame("f3", Dirty ? 36 : 68, 0);

    // Frame 4: second frame_tick during obj0 DRAW.
    set_obj(0, 30, 40, 2, 1'b1);
    push_sprite(20, 58, 0);
    push_sprite(30, 40, 2);
    if (!Dirty) begin
      push_sprite(158, 100, 0);
      push_sprite(158, 100, 1);
    end
    run_frame("f4", Dirty ? 36 : 68, 20);
    check("f4_overrun_pulses", ovr_cnt, 1);
    repeat (4) @(posedge clock);
    #1;
    check("f4_no_second_frame", int'(bus.busy), 0);

    // Frame 5: obj1 disabled, erased only; obj0 to the corner.
    set_obj(0, 0, 0, 7, 1'b1);
    set_obj(1, 158, 100, 1, 1'b0);
    push_sprite(30, 40, 0);
    push_sprite(0, 0, 7);
    push_sprite(158, 100, 0);
    run_frame("f5", 52, 0);

    // Frame 6: obj1 stays disabled, no erase for it.
    set_obj(0, 5, 5, 3, 1'b1);
    push_sprite(0, 0, 0);
    push_sprite(5, 5, 3);
    run_frame("f6", 36, 0);

    // Frame 7: reset during obj0 erase (cycles 2..5 emit erase pixels).
    set_obj(0, 10, 10, 6, 1'b1);
    set_obj(1, 50, 50, 5, 1'b1);
    exp_q.push_back('{x: 8'd5, y: 7'd5, c: 3'd0});
    exp_q.push_back('{x: 8'd6, y: 7'd5, c: 3'd0});
    exp_q.push_back('{x: 8'd7, y: 7'd5, c: 3'd0});
    exp_q.push_back('{x: 8'd8, y: 7'd5, c: 3'd0});
    @(posedge clock); #1;
    bus.frame_tick = 1'b1;
    @(posedge clock); #1;
    bus.frame_tick = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("f7_abort_plot", int'(bus.plot), 0);
    check("f7_abort_busy", int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clock);
    check("f7_pending_pixels", exp_q.size(), 0);

    // Frame 8: prev_valid cleared by reset, draw only.
    push_sprite(10, 10, 6);
    push_sprite(50, 50, 5);
    run_frame("f8", 36, 0);
    check("f8_first_plot", first_plot, 2);

    // Frame 9: identical repeat.
    if (!Dirty) begin
      push_sprite(10, 10, 0);
      push_sprite(10, 10, 6);
      push_sprite(50, 50, 0);
      push_sprite(50, 50, 5);
    end
    run_frame("f9", Dirty ? 4 : 68, 0);
    check("f9_first_plot", first_plot, Dirty ? -1 : 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
